grid_ship_placer: RTL and testbench

Write-side controller for the player's ship grid memory. It accepts one placement command at a time: start cell, length and orientation. It checks the target cells against the grid bounds and against ships already placed, then writes the ship cells with status 2'b01. It sits between the placement UI logic and the grid RAM's read/write port; the RAM's other port is read by the ship renderer.

---
 rtl/grid_ship_placer_if.sv | 26 ++
 rtl/grid_ship_placer.sv | 152 +++++++++++++++
 tb/tb_grid_ship_placer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_ship_placer_if.sv
// Placement command channel plus the grid RAM read/write port of grid_ship_placer.
// The slave modport is the placer's view; the master modport is the UI/RAM side.
interface grid_ship_placer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_x;
  logic [3:0] cmd_y;
  logic [2:0] cmd_len;
  logic       cmd_vertical;
  logic       done;
  logic       ok;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_len, cmd_vertical, mem_rdata,
    input  cmd_ready, done, ok, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_len, cmd_vertical, mem_rdata,
    output cmd_ready, done, ok, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/grid_ship_placer.sv
// Ship placement controller: bounds-checks a command, scans the target cells for
// collisions through a 1-cycle-latency RAM port, then writes the ship cells.
module grid_ship_placer #(
  parameter int GRID_SIZE = 10,
  parameter int MAX_LEN   = 4
) (
  input  logic                clk,
  input  logic                rst,
  grid_ship_placer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;

  localparam logic [4:0] GRID_S = 5'(GRID_SIZE);
  localparam logic [2:0] MAX_L  = 3'(MAX_LEN);

  state_t     state_r;
  logic [3:0] x_r;
  logic [3:0] y_r;
  logic [2:0] len_r;
  logic       vert_r;
  logic [2:0] cnt_r;
  logic       cmd_ready_r;
  logic       done_r;
  logic       ok_r;
  logic       mem_we_r;
  logic [7:0] mem_addr_r;

  logic [4:0] start_s;
  logic [4:0] end_s;
  logic       bounds_ok_s;
  logic [2:0] cnt_next_s;

  // Address of cell idx of a ship; only used once bounds are known to fit.
  function automatic logic [7:0] cell_addr(input logic [3:0] x, input logic [3:0] y,
                                           input logic vert, input logic [2:0] idx);
    logic [3:0] row;
    logic [3:0] col;
    if (vert) begin
      row = y + {1'b0, idx};
      col = x;
    end else begin
      row = y;
      col = x + {1'b0, idx};
    end
    return {row, col};
  endfunction

  // Bounds check on the incoming command, 5 bits wide so the end coordinate cannot wrap.
  always_comb begin
    start_s = 5'd0;
    if (bus.cmd_vertical) begin
      start_s = {1'b0, bus.cmd_y};
    end else begin
      start_s = {1'b0, bus.cmd_x};
    end
    end_s       = start_s + {2'b00, bus.cmd_len} - 5'd1;
    bounds_ok_s = (bus.cmd_len != 3'd0) && (bus.cmd_len <= MAX_L) &&
                  ({1'b0, bus.cmd_x} < GRID_S) && ({1'b0, bus.cmd_y} < GRID_S) &&
                  (end_s < GRID_S);
    cnt_next_s  = cnt_r + 3'd1;
  end

  // Placement FSM; every output is a register so nothing from cmd_* reaches a port combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      x_r         <= 4'd0;
      y_r         <= 4'd0;
      len_r       <= 3'd0;
      vert_r      <= 1'b0;
      cnt_r       <= 3'd0;
      cmd_ready_r <= 1'b1;
      done_r      <= 1'b0;
      ok_r        <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.cmd_valid && cmd_ready_r) begin
            x_r         <= bus.cmd_x;
            y_r         <= bus.cmd_y;
            len_r       <= bus.cmd_len;
            vert_r      <= bus.cmd_vertical;
            cmd_ready_r <= 1'b0;
            if (bounds_ok_s) begin
              state_r    <= CHECK;
              cnt_r      <= 3'd0;
              mem_addr_r <= {bus.cmd_y, bus.cmd_x};
            end else begin
              state_r <= DONE;
              done_r  <= 1'b1;
              ok_r    <= 1'b0;
            end
          end
        end
        CHECK: begin
          // Read data trails the address by one cycle, so it belongs to cell cnt_r-1.
          if ((cnt_r != 3'd0) && (bus.mem_rdata != 2'b00)) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            ok_r    <= 1'b0;
          end else if (cnt_r == len_r) begin
            state_r    <= WRITE;
            cnt_r      <= 3'd0;
            mem_we_r   <= 1'b1;
            mem_addr_r <= cell_addr(x_r, y_r, vert_r, 3'd0);
          end else begin
            cnt_r <= cnt_next_s;
            if (cnt_next_s < len_r) begin
              mem_addr_r <= cell_addr(x_r, y_r, vert_r, cnt_next_s);
            end else begin
              mem_addr_r <= mem_addr_r;
            end
          end
        end
        WRITE: begin
          if (cnt_r == (len_r - 3'd1)) begin
            state_r  <= DONE;
            mem_we_r <= 1'b0;
            done_r   <= 1'b1;
            ok_r     <= 1'b1;
          end else begin
            cnt_r      <= cnt_next_s;
            mem_addr_r <= cell_addr(x_r, y_r, vert_r, cnt_next_s);
          end
        end
        DONE: begin
          state_r     <= IDLE;
          done_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          done_r      <= 1'b0;
          mem_we_r    <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.done      = done_r;
  assign bus.ok        = ok_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_wdata = 2'b01;

endmodule

// File: tb/tb_grid_ship_placer.sv
// Directed bench for grid_ship_placer with a 1-cycle-latency grid RAM model.
module tb_grid_ship_placer;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  logic pre_we;
  logic [7:0] pre_addr;
  logic [1:0] pre_data;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;

  logic [1:0] mem [0:255];
  logic [7:0] wr_addr [$];
  int         wr_edge [$];

  always #5 clk = ~clk;

  grid_ship_placer_if bus ();

  grid_ship_placer #(.GRID_SIZE(10), .MAX_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Grid RAM model: registered read, logged writes, bench-side preload port.
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    bus.mem_rdata <= mem[bus.mem_addr];
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 2'b00;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_addr.push_back(bus.mem_addr);
      wr_edge.push_back(edge_cnt);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int wa(input int i);
    return (i < wr_addr.size()) ? int'(wr_addr[i]) : -1;
  endfunction

  function automatic int we_edge(input int i);
    return (i < wr_edge.size()) ? wr_edge[i] : -100;
  endfunction

  // Issue one command; report the cycle of done (accept edge = cycle 0), ok, and cmd_ready one cycle later.
  task automatic run_cmd(input logic [3:0] x, input logic [3:0] y, input logic [2:0] len,
                         input logic vert, output int done_cyc, output int ok_v, output int rdy_after);
    int w;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_x = x;
    bus.cmd_y = y;
    bus.cmd_len = len;
    bus.cmd_vertical = vert;
    w = 0;
    while (!bus.cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    done_cyc = -1;
    ok_v = -1;
    for (int n = 1; n <= 40; n++) begin
      if (bus.done) begin
        done_cyc = n;
        ok_v = int'(bus.ok);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    rdy_after = int'(bus.cmd_ready);
  endtask

  task automatic preload(input logic [7:0] a, input logic [1:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, okv, rdy, base, n, rdy_seen;
    rst = 1'b1;
    mem_clr = 1'b1;
    pre_we = 1'b0;
    pre_addr = 8'h00;
    pre_data = 2'b00;
    bus.cmd_valid = 1'b0;
    bus.cmd_x = 4'd0;
    bus.cmd_y = 4'd0;
    bus.cmd_len = 3'd0;
    bus.cmd_vertical = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", int'(bus.cmd_ready), 1);
    check("rst_done", int'(bus.done), 0);
    check("rst_ok", int'(bus.ok), 0);
    check("rst_we", int'(bus.mem_we), 0);
    check("rst_addr", int'(bus.mem_addr), 0);
    check("rst_wdata", int'(bus.mem_wdata), 1);
    @(negedge clk);
    rst = 1'b0;
    mem_clr = 1'b0;

    // Horizontal len 3 on an empty grid.
    base = wr_addr.size();
    run_cmd(4'd2, 4'd5, 3'd3, 1'b0, dc, okv, rdy);
    check("h3_done_cyc", dc, 8);
    check("h3_ok", okv, 1);
    check("h3_ready_after", rdy, 1);
    check("h3_wr_count", wr_addr.size() - base, 3);
    check("h3_wr0", wa(base), 'h52);
    check("h3_wr1", wa(base + 1), 'h53);
    check("h3_wr2", wa(base + 2), 'h54);
    check("h3_consec01", we_edge(base + 1) - we_edge(base), 1);
    check("h3_consec12", we_edge(base + 2) - we_edge(base + 1), 1);
    check("h3_mem53", int'(mem[8'h53]), 1);

    // Bounds rejects: vertical end row 10, len 0, len 5, x out of range.
    base = wr_addr.size();
    run_cmd(4'd0, 4'd7, 3'd4, 1'b1, dc, okv, rdy);
    check("vend_done_cyc", dc, 1);
    check("vend_ok", okv, 0);
    check("vend_ready_c2", rdy, 1);
    run_cmd(4'd1, 4'd1, 3'd0, 1'b0, dc, okv, rdy);
    check("len0_done_cyc", dc, 1);
    check("len0_ok", okv, 0);
    run_cmd(4'd1, 4'd1, 3'd5, 1'b0, dc, okv, rdy);
    check("len5_done_cyc", dc, 1);
    check("len5_ok", okv, 0);
    run_cmd(4'd10, 4'd0, 3'd1, 1'b0, dc, okv, rdy);
    check("x10_done_cyc", dc, 1);
    check("x10_ok", okv, 0);
    check("rejects_no_write", wr_addr.size() - base, 0);

    // End column exactly 9 is legal.
    base = wr_addr.size();
    run_cmd(4'd6, 4'd1, 3'd4, 1'b0, dc, okv, rdy);
    check("edge_done_cyc", dc, 10);
    check("edge_ok", okv, 1);
    check("edge_wr_count", wr_addr.size() - base, 4);
    check("edge_wr_last", wa(base + 3), 'h19);

    // Collision at vertical cell index 1 (row 3, col 5).
    preload(8'h35, 2'b01);
    base = wr_addr.size();
    run_cmd(4'd5, 4'd2, 3'd4, 1'b1, dc, okv, rdy);
    check("col1_done_cyc", dc, 4);
    check("col1_ok", okv, 0);
    check("col1_no_write", wr_addr.size() - base, 0);

    // Collision on the last cell, with a non-01 occupied code.
    preload(8'h43, 2'b11);
    base = wr_addr.size();
    run_cmd(4'd0, 4'd4, 3'd4, 1'b0, dc, okv, rdy);
    check("col3_done_cyc", dc, 6);
    check("col3_ok", okv, 0);
    check("col3_no_write", wr_addr.size() - base, 0);

    // Reset during the second WRITE cycle of a len 4 placement.
    base = wr_addr.size();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_x = 4'd0;
    bus.cmd_y = 4'd9;
    bus.cmd_len = 3'd4;
    bus.cmd_vertical = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rw_we_before", int'(bus.mem_we), 1);
    check("rw_addr_before", int'(bus.mem_addr), 'h91);
    rst = 1'b1;
    #1;
    check("rw_we_dropped", int'(bus.mem_we), 0);
    check("rw_ready", int'(bus.cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    check("rw_wr_count", wr_addr.size() - base, 1);
    check("rw_wr0", wa(base), 'h90);
    run_cmd(4'd4, 4'd9, 3'd1, 1'b0, dc, okv, rdy);
    check("rw_next_done_cyc", dc, 4);
    check("rw_next_ok", okv, 1);

    // cmd_valid held with a changing cmd_x while busy.
    base = wr_addr.size();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_x = 4'd0;
    bus.cmd_y = 4'd8;
    bus.cmd_len = 3'd2;
    bus.cmd_vertical = 1'b0;
    @(posedge clk);
    #1;
    n = 1;
    rdy_seen = 0;
    while (!bus.done && n < 40) begin
      if (bus.cmd_ready) rdy_seen = 1;
      @(negedge clk);
      bus.cmd_x = 4'(n);
      @(posedge clk);
      #1;
      n++;
    end
    check("hold_busy_ready", rdy_seen, 0);
    check("hold_done_cyc", n, 6);
    check("hold_ok", int'(bus.ok), 1);
    @(negedge clk);
    bus.cmd_x = 4'd6;
    @(posedge clk);
    #1;
    check("hold_idle_ready", int'(bus.cmd_ready), 1);
    @(posedge clk);
    #1;
    check("hold_accepted", int'(bus.cmd_ready), 0);
    bus.cmd_valid = 1'b0;
    n = 1;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hold2_done_cyc", n, 6);
    check("hold2_ok", int'(bus.ok), 1);
    check("hold_wr_count", wr_addr.size() - base, 4);
    check("hold_wr0", wa(base), 'h80);
    check("hold_wr1", wa(base + 1), 'h81);
    check("hold_wr2", wa(base + 2), 'h86);
    check("hold_wr3", wa(base + 3), 'h87);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
